// File: rtl/adc_frame_pkg.sv
// Shared types and default sizing for the ADC frame reader and its helpers.
package adc_frame_pkg;

    localparam int DEF_DATA_W    = 16;
    localparam int DEF_ADDR_W    = 6;
    localparam int DEF_FRAME_LEN = 52;
    localparam int DEF_RD_LAT    = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN,
        ST_DONE,
        ST_WAIT_LOW
    } state_e;

endpackage

// File: rtl/abs_sat.sv
// Saturating absolute value of a signed sample: the most negative code maps to
// the largest positive magnitude so the result always fits in DATA_W-1 bits.
module abs_sat
    import adc_frame_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic [DATA_W-1:0] x,
    output logic [DATA_W-2:0] mag
);

    logic [DATA_W-1:0] abs_full;

    always_comb begin
        abs_full = x[DATA_W-1] ? (~x + DATA_W'(1)) : x;
        // Only -2^(DATA_W-1) leaves the top bit set after negation.
        mag      = abs_full[DATA_W-1] ? '1 : abs_full[DATA_W-2:0];
    end

endmodule

// File: rtl/adc_frame_reader.sv
// Reads one captured frame from the sample RAM, streams it out and reports the
// frame peak and sum of magnitudes; aborts cleanly if the frame is withdrawn.
module adc_frame_reader
    import adc_frame_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int FRAME_LEN = DEF_FRAME_LEN,
    parameter int RD_LAT    = DEF_RD_LAT,
    parameter int SUM_W     = DATA_W + ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_ready,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] smp_data,
    output logic              smp_valid,
    output logic [DATA_W-2:0] peak,
    output logic [SUM_W-1:0]  sum_abs,
    output logic              result_valid,
    output logic              complete,
    output logic              abort
);

    localparam int                CNT_W      = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0]  LAST_DRAIN = CNT_W'(RD_LAT - 1);

    state_e            state_q, state_d;
    logic              rd_en_q, rd_en_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [CNT_W-1:0]  drain_cnt_q, drain_cnt_d;
    logic [RD_LAT-1:0] vld_q, vld_d;
    logic [DATA_W-2:0] acc_peak_q, acc_peak_d, peak_q, peak_d;
    logic [SUM_W-1:0]  acc_sum_q, acc_sum_d, sum_q, sum_d;
    logic              complete_q, complete_d;
    logic              result_valid_q, result_valid_d;
    logic              abort_q, abort_d;
    logic              drop;
    logic [DATA_W-2:0] smp_mag;

    abs_sat #(.DATA_W(DATA_W)) u_abs_sat (
        .x   (rd_data),
        .mag (smp_mag)
    );

    assign drop = ((state_q == ST_READ) || (state_q == ST_DRAIN)) && !frame_ready;

    always_comb begin
        // NOTE: every _d starts from its _q (or pulse default) so no path infers a latch.
        state_d        = state_q;
        rd_en_d        = rd_en_q;
        rd_addr_d      = rd_addr_q;
        drain_cnt_d    = drain_cnt_q;
        acc_peak_d     = acc_peak_q;
        acc_sum_d      = acc_sum_q;
        peak_d         = peak_q;
        sum_d          = sum_q;
        complete_d     = 1'b0;
        result_valid_d = 1'b0;
        abort_d        = 1'b0;
        vld_d          = (vld_q << 1) | RD_LAT'(rd_en_q);

        if (vld_q[RD_LAT-1]) begin
            acc_peak_d = (smp_mag > acc_peak_q) ? smp_mag : acc_peak_q;
            acc_sum_d  = acc_sum_q + SUM_W'(smp_mag);
        end

        case (state_q)
            ST_IDLE: begin
                if (frame_ready) begin
                    state_d    = ST_READ;
                    rd_en_d    = 1'b1;
                    rd_addr_d  = '0;
                    acc_peak_d = '0;
                    acc_sum_d  = '0;
                end
            end
            ST_READ: begin
                if (rd_addr_q == LAST_ADDR) begin
                    state_d     = ST_DRAIN;
                    rd_en_d     = 1'b0;
                    rd_addr_d   = '0;
                    drain_cnt_d = '0;
                end else begin
                    rd_addr_d = rd_addr_q + ADDR_W'(1);
                end
            end
            ST_DRAIN: begin
                // The last sample lands on this edge, so publish the updated accumulators.
                if (drain_cnt_q == LAST_DRAIN) begin
                    state_d        = ST_DONE;
                    complete_d     = 1'b1;
                    result_valid_d = 1'b1;
                    peak_d         = acc_peak_d;
                    sum_d          = acc_sum_d;
                end else begin
                    drain_cnt_d = drain_cnt_q + CNT_W'(1);
                end
            end
            ST_DONE:     state_d = ST_WAIT_LOW;
            ST_WAIT_LOW: if (!frame_ready) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase

        if (drop) begin
            state_d        = ST_IDLE;
            rd_en_d        = 1'b0;
            rd_addr_d      = '0;
            vld_d          = '0;
            complete_d     = 1'b0;
            result_valid_d = 1'b0;
            peak_d         = peak_q;
            sum_d          = sum_q;
            abort_d        = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values.
        if (rst) begin
            state_q        <= ST_IDLE;
            rd_en_q        <= 1'b0;
            rd_addr_q      <= '0;
            drain_cnt_q    <= '0;
            vld_q          <= '0;
            acc_peak_q     <= '0;
            acc_sum_q      <= '0;
            peak_q         <= '0;
            sum_q          <= '0;
            complete_q     <= 1'b0;
            result_valid_q <= 1'b0;
            abort_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            rd_en_q        <= rd_en_d;
            rd_addr_q      <= rd_addr_d;
            drain_cnt_q    <= drain_cnt_d;
            vld_q          <= vld_d;
            acc_peak_q     <= acc_peak_d;
            acc_sum_q      <= acc_sum_d;
            peak_q         <= peak_d;
            sum_q          <= sum_d;
            complete_q     <= complete_d;
            result_valid_q <= result_valid_d;
            abort_q        <= abort_d;
        end
    end

    assign rd_en        = rd_en_q;
    assign rd_addr      = rd_addr_q;
    assign smp_valid    = vld_q[RD_LAT-1];
    assign smp_data     = vld_q[RD_LAT-1] ? rd_data : '0;
    assign peak         = peak_q;
    assign sum_abs      = sum_q;
    assign result_valid = result_valid_q;
    assign complete     = complete_q;
    assign abort        = abort_q;

endmodule

// File: tb/tb_adc_frame_reader.sv
// Randomized bench for adc_frame_reader: a RAM model feeds the reader and each
// frame is compared cycle by cycle against expectations computed from the RAM image.
module tb_adc_frame_reader;

    localparam int DATA_W    = 16;
    localparam int ADDR_W    = 6;
    localparam int FRAME_LEN = 52;
    localparam int RD_LAT    = 2;
    localparam int SUM_W     = DATA_W + ADDR_W;
    localparam int MAX_MAG   = (1 << (DATA_W - 1)) - 1;
    localparam int DONE_N    = FRAME_LEN + RD_LAT;

    logic              clk;
    logic              rst;
    logic              frame_ready;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] smp_data;
    logic              smp_valid;
    logic [DATA_W-2:0] peak;
    logic [SUM_W-1:0]  sum_abs;
    logic              result_valid;
    logic              complete;
    logic              abort;

    adc_frame_reader #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .FRAME_LEN (FRAME_LEN),
        .RD_LAT    (RD_LAT),
        .SUM_W     (SUM_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .frame_ready  (frame_ready),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .smp_data     (smp_data),
        .smp_valid    (smp_valid),
        .peak         (peak),
        .sum_abs      (sum_abs),
        .result_valid (result_valid),
        .complete     (complete),
        .abort        (abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sample RAM with RD_LAT cycles from address to data.
    logic [DATA_W-1:0] ram [FRAME_LEN];
    logic [DATA_W-1:0] rd_pipe [RD_LAT];

    always @(posedge clk) begin
        rd_pipe[0] <= (rd_en && int'(rd_addr) < FRAME_LEN) ? ram[int'(rd_addr)] : 16'hDEAD;
        for (int k = 1; k < RD_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
    assign rd_data = rd_pipe[RD_LAT-1];

    int n_checks = 0;
    int n_pass   = 0;
    int exp_peak = 0;
    int exp_sum  = 0;
    int n_complete_exp = 0;
    int n_abort_exp    = 0;
    int n_bursts_exp   = 0;

    // Pulse and burst counters observed over the whole run.
    int   n_complete = 0;
    int   n_abort    = 0;
    int   n_bursts   = 0;
    int   n_overlap  = 0;
    logic rd_en_prev = 1'b0;

    always @(negedge clk) begin
        if (complete) n_complete++;
        if (abort) n_abort++;
        if (complete && abort) n_overlap++;
        if (rd_en && !rd_en_prev) n_bursts++;
        rd_en_prev = rd_en;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic void model_frame(output int pk, output int sm);
        pk = 0;
        sm = 0;
        for (int i = 0; i < FRAME_LEN; i++) begin
            int v;
            int a;
            v = $signed(ram[i]);
            a = (v < 0) ? -v : v;
            if (a > MAX_MAG) a = MAX_MAG;
            if (a > pk) pk = a;
            sm += a;
        end
    endfunction

    function automatic void fill_random();
        for (int i = 0; i < FRAME_LEN; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r == 0)      ram[i] = 16'h8000;
            else if (r == 1) ram[i] = 16'h7FFF;
            else             ram[i] = DATA_W'($urandom);
        end
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_rd_en"}, rd_en, 0);
        check({tag, "_rd_addr"}, rd_addr, 0);
        check({tag, "_smp_valid"}, smp_valid, 0);
        check({tag, "_smp_data"}, smp_data, 0);
        check({tag, "_peak"}, peak, 0);
        check({tag, "_sum_abs"}, sum_abs, 0);
        check({tag, "_result_valid"}, result_valid, 0);
        check({tag, "_complete"}, complete, 0);
        check({tag, "_abort"}, abort, 0);
    endtask

    task automatic idle_cycles(input int k);
        for (int i = 0; i < k; i++) begin
            @(negedge clk);
            check("idle_rd_en", rd_en, 0);
            check("idle_smp_valid", smp_valid, 0);
            check("idle_complete", complete, 0);
        end
    endtask

    task automatic abort_tail();
        n_abort_exp++;
        @(negedge clk);
        check("abort_pulse", abort, 1);
        check("abort_rd_en", rd_en, 0);
        check("abort_complete", complete, 0);
        check("abort_result_valid", result_valid, 0);
        check("abort_smp_valid", smp_valid, 0);
        check("abort_peak_held", peak, exp_peak);
        check("abort_sum_held", sum_abs, exp_sum);
        for (int i = 0; i < RD_LAT + 3; i++) begin
            @(negedge clk);
            check("post_abort_smp_valid", smp_valid, 0);
            check("post_abort_abort", abort, 0);
            check("post_abort_rd_en", rd_en, 0);
        end
    endtask

    task automatic reset_tail();
        @(negedge clk);
        check_all_zero("midreset");
        exp_peak = 0;
        exp_sum  = 0;
        rst = 1'b0;
    endtask

    // Called just after a falling edge; the next rising edge is E0.
    task automatic do_frame(input int drop_at, input int rst_at, input int hold);
        int pk;
        int sm;
        model_frame(pk, sm);
        n_bursts_exp++;
        frame_ready = 1'b1;
        for (int n = 0; n <= DONE_N; n++) begin
            logic vexp;
            logic done;
            @(negedge clk);
            check("rd_en", rd_en, n < FRAME_LEN);
            if (n < FRAME_LEN) check("rd_addr", rd_addr, n);
            vexp = (n >= RD_LAT) && (n < DONE_N);
            check("smp_valid", smp_valid, vexp);
            if (vexp) check("smp_data", smp_data, ram[n-RD_LAT]);
            done = (n == DONE_N);
            check("complete", complete, done);
            check("result_valid", result_valid, done);
            check("abort_idle", abort, 0);
            if (done) begin
                exp_peak = pk;
                exp_sum  = sm;
                n_complete_exp++;
            end
            check("peak", peak, exp_peak);
            check("sum_abs", sum_abs, exp_sum);
            if (n == drop_at) begin
                frame_ready = 1'b0;
                abort_tail();
                return;
            end
            if (n == rst_at) begin
                rst = 1'b1;
                reset_tail();
                return;
            end
        end
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check("stale_high_rd_en", rd_en, 0);
            check("stale_high_complete", complete, 0);
            check("stale_high_result_valid", result_valid, 0);
        end
        frame_ready = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        frame_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        idle_cycles(2);

        for (int i = 0; i < FRAME_LEN; i++) ram[i] = DATA_W'(i - 26);
        do_frame(-1, -1, 1);
        check("ramp_peak", peak, 26);
        check("ramp_sum", sum_abs, 676);
        idle_cycles(3);

        for (int i = 0; i < FRAME_LEN; i++) ram[i] = '0;
        ram[$urandom_range(0, FRAME_LEN - 1)] = 16'h8000;
        do_frame(-1, -1, 1);
        check("sat_peak", peak, 32767);
        check("sat_sum", sum_abs, 32767);
        idle_cycles(3);

        for (int i = 0; i < FRAME_LEN; i++) ram[i] = 16'h8000;
        do_frame(-1, -1, 0);
        check("fullscale_peak", peak, 32767);
        check("fullscale_sum", sum_abs, 1703884);
        idle_cycles(3);

        fill_random();
        do_frame(-1, -1, 5);
        idle_cycles(3);
        fill_random();
        do_frame(-1, -1, 1);
        idle_cycles(3);

        fill_random();
        do_frame(20, -1, 0);
        fill_random();
        do_frame($urandom_range(0, DONE_N - 1), -1, 0);

        fill_random();
        do_frame(-1, 30, 0);
        do_frame(-1, -1, 1);
        idle_cycles(3);

        repeat (4) begin
            fill_random();
            do_frame(-1, -1, $urandom_range(0, 4));
            idle_cycles($urandom_range(2, 4));
        end

        #1;
        check("complete_pulses", n_complete, n_complete_exp);
        check("abort_pulses", n_abort, n_abort_exp);
        check("read_bursts", n_bursts, n_bursts_exp);
        check("complete_abort_overlap", n_overlap, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/adc_frame_reader.md
# adc_frame_reader

Consumer side of the ADC frame-capture buffer: waits for the capture block's frame-ready level, sweeps the dual-port sample RAM read port over one full frame, streams the samples out, computes per-frame peak and sum of absolute values for the AGC loop, then pulses `complete` so the capture block re-arms. Runs on the same clock as the RAM read port. Sits between the capture buffer and the AGC gain calculator.

## Interface
Parameters:
- `DATA_W`, 16, sample width, signed two's complement
- `ADDR_W`, 6, RAM address width
- `FRAME_LEN`, 52, samples per frame, addresses 0..FRAME_LEN-1; must be ≤ 2^ADDR_W
- `RD_LAT`, 2, RAM read latency in cycles, address to `rd_data`, ≥1
- `SUM_W`, DATA_W+ADDR_W, width of `sum_abs`

Ports:
- `clk`  in  1  single clock; also drives the RAM read clock
- `rst`  in  1  synchronous, active-high reset
- `frame_ready`  in  1  level from the capture block, high while a full frame is held
- `rd_en`  out  1  RAM read enable
- `rd_addr`  out  ADDR_W  RAM read address
- `rd_data`  in  DATA_W  RAM read data, valid RD_LAT cycles after address
- `smp_data`  out  DATA_W  streamed sample
- `smp_valid`  out  1  one-cycle qualifier per sample, no backpressure
- `peak`  out  DATA_W-1  max |sample| of the last frame
- `sum_abs`  out  SUM_W  Σ|sample| of the last frame
- `result_valid`  out  1  one-cycle pulse, `peak`/`sum_abs` updated
- `complete`  out  1  one-cycle pulse to the capture block
- `abort`  out  1  one-cycle pulse, frame dropped on protocol violation

## Operation
- FSM states: IDLE, READ, DRAIN, DONE, WAIT_LOW.
- IDLE: `rd_en`=0, `rd_addr`=0. `frame_ready`=1 at an edge → READ; accumulators cleared at that edge.
- READ: `rd_en`=1; `rd_addr` takes 0,1,…,FRAME_LEN-1, one per cycle. After FRAME_LEN-1 is issued → DRAIN.
- DRAIN: `rd_en`=0; stays RD_LAT cycles while the last reads return → DONE.
- A length-RD_LAT valid shift register tracks issued reads. Each returning word drives `smp_data`/`smp_valid` and updates `peak` = max(peak, |x|) and `sum_abs` += |x|.
- |x| saturates: -2^(DATA_W-1) → 2^(DATA_W-1)-1. The sum never wraps, since SUM_W covers FRAME_LEN·max.
- DONE: one cycle. `complete`=1 and `result_valid`=1. → WAIT_LOW.
- WAIT_LOW: hold until `frame_ready`=0 → IDLE. The capture block drops its level one cycle after `complete`, so the reader must not retrigger on the stale high.
- `frame_ready` falling during READ or DRAIN:
  - pulse `abort` and go to IDLE.
  - no `complete`, no `result_valid`; `peak`/`sum_abs` keep the previous frame's values.
  - in-flight reads are discarded, no further `smp_valid`.
- `peak`/`sum_abs` are held between frames and change only at `result_valid`.

## Timing
- Reset values: all outputs 0, state IDLE, valid pipe cleared.
- Reset mid-frame: immediate return to IDLE, no `complete`. If `frame_ready` is still high after reset, a fresh read of the same frame starts.
- Edge E0 samples `frame_ready`=1 in IDLE.
- `rd_addr`=i is driven in the cycle after E0+i.
- `smp_valid` for sample i is high in the cycle after E0+i+RD_LAT.
- `complete`/`result_valid` are high in the cycle after E0+FRAME_LEN+RD_LAT; the defaults give E0+54.
- Minimum re-arm: one cycle in WAIT_LOW after `frame_ready` falls, then IDLE.
- `complete` and `abort` are never high in the same cycle.

## Structure
- Package `adc_frame_pkg`: FSM state enum; default constants FRAME_LEN=52, RD_LAT=2, DATA_W=16.
- Sub-module `abs_sat`: combinational saturating absolute value, DATA_W in, DATA_W-1 out. It is reused by the AGC gain block.
- Top level holds the FSM, address counter, valid pipe and accumulators.

## Test plan
- Ramp frame: RAM holds i-26 at address i (values -26..25), `frame_ready` raised → 52 `smp_valid` samples in order, `peak`=26, `sum_abs`=676, `complete` in the cycle after E0+54.
- Saturation: one sample -32768, rest 0 → `peak`=32767, `sum_abs`=32767.
- Full scale: all 52 samples -32768 → `sum_abs`=1703884, no overflow.
- Re-arm: `frame_ready` held 1 cycle after `complete`, then low, then high again 3 cycles later → exactly two frames, two `complete` pulses, no extra read burst.
- Abort: `frame_ready` dropped at address 20 → `abort` pulse, no `complete`, `peak`/`sum_abs` unchanged from the prior frame, `rd_en`=0 the next cycle.
- Reset at address 30 with `frame_ready` held high → all outputs 0, then a full 52-sample read restarting at address 0.
